add_serial_arb: RTL and testbench
=================================

ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; the port widths below assume 4.
REQ-002 Parameter W, default 8: operand and sum width.
REQ-003 Parameter ADD_LAT, default 9: cycles from the add_en pulse to a valid add_out (1 load cycle plus W shift cycles).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NREQ  per-requester add request; held high until that requester's resp_valid.
REQ-007 req_a  input  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
REQ-008 req_b  input  NREQ*W  packed operand B, same packing as req_a.
REQ-009 gnt  output  NREQ  one-hot grant; all zero when idle.
REQ-010 resp_valid  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 resp_sum  output  W  sum for the requester flagged by resp_valid.
REQ-012 add_en  output  1  start pulse to the shared serial adder.
REQ-013 add_a  output  W  operand A to the adder.
REQ-014 add_b  output  W  operand B to the adder.
REQ-015 add_out  input  W  adder result, sampled ADD_LAT cycles after add_en.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, CAPTURE; encoding is 2 bits.
REQ-017 IDLE: if any req bit is high, the FSM latches the winner index, sets gnt one-hot, and moves to ISSUE; otherwise it stays in IDLE.
REQ-018 Arbitration is round-robin. The search starts at (last_served+1) mod NREQ. last_served resets to NREQ-1, so requester 0 wins first after reset.
REQ-019 ISSUE: add_en=1 for exactly one cycle; add_a/add_b = the winner's operands; wait counter loads ADD_LAT-1; next state WAIT.
REQ-020 add_a/add_b hold the winner's operands from ISSUE through CAPTURE, and hold their last value otherwise.
REQ-021 WAIT: the counter decrements each cycle; at 0 the FSM moves to CAPTURE. add_out is therefore sampled exactly ADD_LAT cycles after add_en.
REQ-022 CAPTURE: resp_sum <= add_out; resp_valid[winner] pulses 1 for one cycle; last_served <= winner; gnt clears; next state IDLE.
REQ-023 resp_sum holds its value until the next CAPTURE.
REQ-024 Minimum spacing between add_en pulses is ADD_LAT+3 cycles; there are no back-to-back issues.
REQ-025 Arbitration is decided only in IDLE; a req rising or dropping during ISSUE/WAIT/CAPTURE does not change the grant.
REQ-026 If the granted req drops before CAPTURE, the operation still completes and resp_valid still pulses (no abort).
REQ-027 Sum arithmetic is modulo 2^W; carry out is discarded.
REQ-028 Simultaneous requests are resolved by REQ-018 only; there is no starvation, and worst-case wait is (NREQ-1)*(ADD_LAT+3) cycles.
REQ-029 An illegal state code returns the FSM to IDLE on the next edge.

Reset
REQ-030 While rst=0, these outputs are 0: gnt, resp_valid, resp_sum, add_en, add_a, add_b.
REQ-031 While rst=0: state=IDLE, counter=0, last_served=NREQ-1.
REQ-032 Reset asserted mid-operation abandons the operation: no resp_valid is produced, and the first request after release is re-arbitrated from IDLE.

Configuration
REQ-033 Macro ADD_SERIAL_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins, and last_served is unused.
- Undefined: round-robin per REQ-018.
- All other behaviour is identical in both builds.

Verification
REQ-034 Single request: req=0001, a0=0x15, b0=0x2A, adder model returns a+b -> add_en pulses one cycle after req. resp_valid=0001 occurs ADD_LAT+1 cycles after add_en, with resp_sum=0x3F.
REQ-035 Wrap-around: req=0010, a1=0xFF, b1=0x02 -> resp_sum=0x01, resp_valid=0010.
REQ-036 All four requests held high from reset release (round-robin build) -> grant order 0,1,2,3,0. add_en pulses are spaced exactly ADD_LAT+3 cycles apart.
REQ-037 Same stimulus as REQ-036 with ADD_SERIAL_ARB_FIXED_PRIO_EN defined -> requester 0 is granted repeatedly while req[0] is high; requester 1 is granted only after req[0] drops.
REQ-038 rst pulsed low during WAIT -> all outputs are 0 immediately (asynchronous), no resp_valid occurs, and after release requester 0 is granted first.
REQ-039 Granted req dropped during WAIT -> resp_valid still pulses for that requester with the correct sum.

Source files
------------

// File: rtl/add_serial_arb.sv
`default_nettype none
// ============================================================================
//  Module      : add_serial_arb
//  Description : Arbitrates NREQ requesters onto one shared serial adder.
//                A grant is decided in IDLE. The winner's operands are then
//                presented to the adder, and add_en is pulsed for one cycle.
//                The result is captured ADD_LAT cycles later, and a one-cycle
//                resp_valid is returned to the winner.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-low reset
//                req        - per-requester request, held until resp_valid
//                req_a/b    - packed operands, requester i at [i*W +: W]
//                gnt        - one-hot grant, zero when idle
//                resp_valid - one-cycle completion pulse to the winner
//                resp_sum   - result for the requester flagged by resp_valid
//                add_en     - start pulse to the shared adder
//                add_a/b    - operands to the adder
//                add_out    - adder result
//  Config      : ADD_SERIAL_ARB_FIXED_PRIO_EN - when defined, the lowest
//                requesting index wins (fixed priority) instead of the
//                default round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_serial_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int ADD_LAT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_sum,
    output logic              add_en,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [W-1:0]        add_a_q, add_a_d;
    logic [W-1:0]        add_b_q, add_b_d;
    logic [W-1:0]        sum_q, sum_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

    // Winner selection, evaluated every cycle but only consumed in IDLE.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef ADD_SERIAL_ARB_FIXED_PRIO_EN
        // Walk downwards so the lowest requesting index is the last to win.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
`else
        // Search starts just after the last served requester and wraps.
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (int'(last_q) + 1 + k) % NREQ;
            if (!win_found && req[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        winner_d   = winner_q;
        gnt_d      = gnt_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        sum_d      = sum_q;
        add_en     = 1'b0;
        resp_valid = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    winner_d = win_idx;
                    gnt_d    = NREQ'(1) << win_idx;
                    // Operands are latched here so they are stable on add_a/b
                    // for the whole ISSUE cycle.
                    add_a_d  = req_a[int'(win_idx)*W +: W];
                    add_b_d  = req_b[int'(win_idx)*W +: W];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_en  = 1'b1;
                cnt_d   = CNT_W'(ADD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // The sum is taken on the edge entering CAPTURE, which is
                    // ADD_LAT edges after the adder saw add_en. This lets
                    // resp_sum be valid in the same cycle as resp_valid.
                    sum_d   = add_out;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                resp_valid = gnt_q;
                last_d     = winner_q;
                gnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            winner_q <= '0;
            gnt_q    <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            sum_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            sum_q    <= sum_d;
        end
    end

    assign gnt      = gnt_q;
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign resp_sum = sum_q;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_serial_arb
//  Description : Self-checking bench for add_serial_arb. It contains a
//                latency-accurate adder model and a request-level reference
//                model that predicts the arbitration order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_serial_arb;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int ADD_LAT = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_sum;
    logic              add_en;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_out = '0;

    int checks = 0;
    int errors = 0;
    int last_srv = NREQ - 1;
    logic [W-1:0] opa [NREQ];
    logic [W-1:0] opb [NREQ];

    add_serial_arb #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .add_en     (add_en),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_out    (add_out)
    );

    always #5 clk = ~clk;

    // Adder model: the result is presented only during the single cycle in
    // which it must be sampled (ADD_LAT edges after the edge that saw add_en).
    // In every other cycle it shows the inverted sum, so early or late
    // sampling is caught.
    logic [W-1:0] m_sum = '0;
    int           m_k = 0;
    bit           m_pend = 1'b0;
    always @(negedge clk) begin
        if (add_en) begin
            m_pend = 1'b1;
            m_k    = 0;
            m_sum  = add_a + add_b;
        end else if (m_pend) begin
            m_k++;
        end
        add_out = (m_pend && m_k == ADD_LAT) ? m_sum : ~m_sum;
    end

    // Reference arbitration: picks the next pending requester by the policy rule.
    function automatic int exp_winner(input logic [NREQ-1:0] pend, input int last);
        int w;
        w = -1;
`ifdef ADD_SERIAL_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (pend[i]) w = i;
`else
        for (int k = NREQ; k >= 1; k--) if (pend[(last + k) % NREQ]) w = (last + k) % NREQ;
`endif
        return w;
    endfunction

    task automatic apply(input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
        req = r;
    endtask

    task automatic wait_add_en(output int cyc, output bit ok);
        ok = 1'b0; cyc = 0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            @(negedge clk);
            if (add_en === 1'b1) begin ok = 1'b1; cyc = i; end
        end
    endtask

    task automatic wait_resp(output int cyc, output bit ok);
        ok = 1'b0; cyc = 0;
        for (int i = 1; i <= 100 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid !== '0) begin ok = 1'b1; cyc = i; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        checks++; if ({add_en, add_a, add_b, resp_sum} !== '0) begin errors++;
            $display("FAIL reset_outs: en=%b a=%h b=%h sum=%h want all 0", add_en, add_a, add_b, resp_sum); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_srv = NREQ - 1;
    endtask

    task automatic test_single();
        int cyc; bit ok;
        @(negedge clk);
        opa[0] = 8'h15; opb[0] = 8'h2A;
        apply(4'b0001);
        wait_add_en(cyc, ok);
        checks++; if (!ok || cyc != 1) begin errors++; $display("FAIL single_en_latency: got %0d (ok=%0d) want 1", cyc, ok); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        checks++; if ({add_a, add_b} !== {8'h15, 8'h2A}) begin errors++; $display("FAIL single_ops: got %h/%h want 15/2a", add_a, add_b); end
        wait_resp(cyc, ok);
        checks++; if (!ok || cyc != ADD_LAT + 1) begin errors++; $display("FAIL single_resp_latency: got %0d want %0d", cyc, ADD_LAT + 1); end
        checks++; if (resp_valid !== 4'b0001 || resp_sum !== 8'h3F) begin errors++;
            $display("FAIL single_resp: got %b/%h want 0001/3f", resp_valid, resp_sum); end
        apply(4'b0000);
        last_srv = 0;
        @(negedge clk);
        checks++; if (resp_valid !== '0 || gnt !== '0) begin errors++; $display("FAIL single_pulse: valid=%b gnt=%b want 0/0", resp_valid, gnt); end
        checks++; if (resp_sum !== 8'h3F) begin errors++; $display("FAIL single_hold: got %h want 3f", resp_sum); end
    endtask

    task automatic test_wrap();
        int cyc; bit ok;
        opa[1] = 8'hFF; opb[1] = 8'h02;
        apply(4'b0010);
        wait_add_en(cyc, ok);
        checks++; if (!ok || gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt: got %b want 0010", gnt); end
        wait_resp(cyc, ok);
        checks++; if (resp_valid !== 4'b0010 || resp_sum !== 8'h01) begin errors++;
            $display("FAIL wrap_resp: got %b/%h want 0010/01", resp_valid, resp_sum); end
        apply(4'b0000);
        last_srv = 1;
    endtask

    task automatic test_drop();
        int cyc; bit ok;
        opa[3] = 8'hC3; opb[3] = 8'h5A;
        @(negedge clk);
        apply(4'b1000);
        wait_add_en(cyc, ok);
        checks++; if (!ok || gnt !== 4'b1000) begin errors++; $display("FAIL drop_gnt: got %b want 1000", gnt); end
        repeat (3) @(negedge clk);
        apply(4'b0000);
        wait_resp(cyc, ok);
        checks++; if (!ok || cyc + 3 != ADD_LAT + 1) begin errors++; $display("FAIL drop_latency: got %0d want %0d", cyc + 3, ADD_LAT + 1); end
        checks++; if (resp_valid !== 4'b1000 || resp_sum !== 8'h1D) begin errors++;
            $display("FAIL drop_resp: got %b/%h want 1000/1d", resp_valid, resp_sum); end
        last_srv = 3;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] pend, nw;
        int cyc, w, r; bit ok, first;
        @(negedge clk);
        pend = NREQ'($urandom_range(1, 15));
        for (int i = 0; i < NREQ; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
        apply(pend);
        first = 1'b1;
        for (int n = 0; n < 40 && pend != '0; n++) begin
            wait_add_en(cyc, ok);
            checks++; if (!ok || cyc != (first ? 1 : 2)) begin errors++;
                $display("FAIL rand_en_spacing: txn %0d got %0d (ok=%0d) want %0d", n, cyc, ok, first ? 1 : 2); end
            if (!ok) return;
            w = exp_winner(pend, last_srv);
            checks++; if (gnt !== NREQ'(1 << w)) begin errors++; $display("FAIL rand_gnt: txn %0d got %b want %b", n, gnt, NREQ'(1 << w)); end
            checks++; if ({add_a, add_b} !== {opa[w], opb[w]}) begin errors++;
                $display("FAIL rand_ops: txn %0d got %h/%h want %h/%h", n, add_a, add_b, opa[w], opb[w]); end
            // New requests arriving mid-operation must not disturb the grant.
            r = $urandom_range(1, 8);
            repeat (r) @(negedge clk);
            if (n < 20) begin
                nw = NREQ'($urandom) & ~pend;
                for (int i = 0; i < NREQ; i++) if (nw[i]) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
                pend = pend | nw;
                apply(pend);
            end
            wait_resp(cyc, ok);
            checks++; if (!ok || r + cyc != ADD_LAT + 1) begin errors++; $display("FAIL rand_latency: txn %0d got %0d want %0d", n, r + cyc, ADD_LAT + 1); end
            checks++; if (resp_valid !== NREQ'(1 << w) || resp_sum !== W'(opa[w] + opb[w])) begin errors++;
                $display("FAIL rand_resp: txn %0d got %b/%h want %b/%h", n, resp_valid, resp_sum, NREQ'(1 << w), W'(opa[w] + opb[w])); end
            last_srv = w;
            pend[w] = 1'b0;
            if (n < 20 && pend == '0) begin
                pend = NREQ'($urandom_range(1, 15));
                for (int i = 0; i < NREQ; i++) if (pend[i]) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
            end
            apply(pend);
            first = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; bit seen;
        @(negedge clk);
        opa[2] = 8'h11; opb[2] = 8'h22; opa[0] = 8'h40; opb[0] = 8'h05;
        apply(4'b0100);
        wait_add_en(cyc, ok);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({gnt, resp_valid, add_en, add_a, add_b, resp_sum} !== '0) begin errors++;
            $display("FAIL midrst_outs: gnt=%b v=%b en=%b a=%h b=%h sum=%h want all 0", gnt, resp_valid, add_en, add_a, add_b, resp_sum); end
        apply(4'b0101);
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (resp_valid !== '0) seen = 1'b1; end
        rst_n = 1'b1;
        last_srv = NREQ - 1;
        wait_add_en(cyc, ok);
        checks++; if (!ok || gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt: got %b want 0001", gnt); end
        wait_resp(cyc, ok);
        checks++; if (seen || resp_valid !== 4'b0001 || resp_sum !== 8'h45) begin errors++;
            $display("FAIL midrst_resp: stray=%0d got %b/%h want 0001/45", seen, resp_valid, resp_sum); end
        apply(4'b0000);
        last_srv = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_held();
        logic [NREQ-1:0] pend;
        int cyc, prev, w; bit ok;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
        pend = 4'b1111;
        apply(pend);
        @(negedge clk);
        rst_n = 1'b1;
        last_srv = NREQ - 1;
        prev = 0;
        for (int n = 0; n < 8; n++) begin
            wait_add_en(cyc, ok);
            if (n > 0) begin
                checks++; if (!ok || prev + cyc != ADD_LAT + 3) begin errors++;
                    $display("FAIL held_spacing: txn %0d got %0d want %0d", n, prev + cyc, ADD_LAT + 3); end
            end
            if (!ok) return;
            w = exp_winner(pend, last_srv);
            checks++; if (gnt !== NREQ'(1 << w)) begin errors++; $display("FAIL held_gnt: txn %0d got %b want %b", n, gnt, NREQ'(1 << w)); end
            wait_resp(cyc, ok);
            prev = cyc;
            checks++; if (resp_valid !== NREQ'(1 << w) || resp_sum !== W'(opa[w] + opb[w])) begin errors++;
                $display("FAIL held_resp: txn %0d got %b/%h want %b/%h", n, resp_valid, resp_sum, NREQ'(1 << w), W'(opa[w] + opb[w])); end
            last_srv = w;
            if (n == 4) pend[0] = 1'b0;
            if (n == 7) pend = '0;
            apply(pend);
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        test_reset();
        test_single();
        test_wrap();
        test_drop();
        test_random();
        test_reset_mid();
        test_all_held();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
